// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Instruction handshake and ALU/register-file control bundle
//               for alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_sel;
    logic        alu_en;
    logic [3:0]  rf_ra;
    logic [3:0]  rf_rb;
    logic [3:0]  rf_wa;
    logic        rf_we;
    logic        illegal;
    logic [7:0]  retired;

    // Instruction source / control consumer side
    modport master (
        output instr_valid,
        output instr,
        input  instr_ready,
        input  alu_sel,
        input  alu_en,
        input  rf_ra,
        input  rf_rb,
        input  rf_wa,
        input  rf_we,
        input  illegal,
        input  retired
    );

    // Sequencer side
    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready,
        output alu_sel,
        output alu_en,
        output rf_ra,
        output rf_rb,
        output rf_wa,
        output rf_we,
        output illegal,
        output retired
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Four-state IDLE/DECODE/EXEC/WB instruction sequencer driving
//               ALU select/enable and register-file read/write controls.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer (
    input  wire                    clk,
    input  wire                    rst_n,
    alu_op_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] C_OP_NOP = 4'h8;

    state_t      state_q,   state_d;
    logic [15:0] ir_q,      ir_d;
    logic [2:0]  alu_sel_q, alu_sel_d;
    logic        alu_en_q,  alu_en_d;
    logic [3:0]  rf_ra_q,   rf_ra_d;
    logic [3:0]  rf_rb_q,   rf_rb_d;
    logic [3:0]  rf_wa_q,   rf_wa_d;
    logic        rf_we_q,   rf_we_d;
    logic        illegal_q, illegal_d;
    logic [7:0]  retired_q, retired_d;

    logic        w_is_alu;
    logic        w_is_nop;

    // Opcodes 0x0-0x7 are ALU ops, 0x8 is NOP, everything else is illegal
    assign w_is_alu = ~ir_q[15];
    assign w_is_nop = (ir_q[15:12] == C_OP_NOP);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_sel_d = alu_sel_q;
        alu_en_d  = 1'b0;
        rf_ra_d   = rf_ra_q;
        rf_rb_d   = rf_rb_q;
        rf_wa_d   = rf_wa_q;
        rf_we_d   = 1'b0;
        illegal_d = 1'b0;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                // Read addresses come straight from the accepted word so they
                // are already valid while the instruction sits in DECODE.
                if (bus.instr_valid) begin
                    ir_d    = bus.instr;
                    rf_ra_d = bus.instr[7:4];
                    rf_rb_d = bus.instr[3:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rf_ra_d = ir_q[7:4];
                rf_rb_d = ir_q[3:0];
                if (w_is_alu) begin
                    alu_sel_d = ir_q[14:12];
                    state_d   = ST_EXEC;
                end else if (w_is_nop) begin
                    retired_d = retired_q + 8'd1;
                    state_d   = ST_IDLE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_en_d = 1'b1;
                state_d  = ST_WB;
            end
            ST_WB: begin
                rf_we_d   = 1'b1;
                rf_wa_d   = ir_q[11:8];
                retired_d = retired_q + 8'd1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ir_q      <= 16'h0000;
            alu_sel_q <= 3'b000;
            alu_en_q  <= 1'b0;
            rf_ra_q   <= 4'h0;
            rf_rb_q   <= 4'h0;
            rf_wa_q   <= 4'h0;
            rf_we_q   <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_sel_q <= alu_sel_d;
            alu_en_q  <= alu_en_d;
            rf_ra_q   <= rf_ra_d;
            rf_rb_q   <= rf_rb_d;
            rf_wa_q   <= rf_wa_d;
            rf_we_q   <= rf_we_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.alu_sel     = alu_sel_q;
    assign bus.alu_en      = alu_en_q;
    assign bus.rf_ra       = rf_ra_q;
    assign bus.rf_rb       = rf_rb_q;
    assign bus.rf_wa       = rf_wa_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;

`ifndef SYNTHESIS
    a_illegal_single: assert property (@(posedge clk) disable iff (!rst_n)
        illegal_q |=> !illegal_q);
    a_en_we_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(alu_en_q && rf_we_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed, table-driven self-checking bench for alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam logic [1:0] K_ALU = 2'd0;
    localparam logic [1:0] K_NOP = 2'd1;
    localparam logic [1:0] K_ILL = 2'd2;

    typedef struct {
        logic [15:0] instr;
        logic [1:0]  kind;
        logic [2:0]  exp_sel;
        logic [3:0]  exp_ra;
        logic [3:0]  exp_rb;
        logic [3:0]  exp_wa;
        logic [7:0]  exp_retired;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_op_sequencer_if bus();

    alu_op_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Applies one vector from acceptance until the sequencer is back in IDLE;
    // a junk word is held valid meanwhile, which must be ignored.
    task automatic run_vec(input vec_t v, input int idx);
        bus.instr_valid = 1'b1;
        bus.instr       = v.instr;
        tick();
        bus.instr = 16'hF0F0;
        chk($sformatf("v%0d decode ready", idx), {15'd0, bus.instr_ready}, 16'd0);
        chk($sformatf("v%0d decode rf_ra", idx), {12'd0, bus.rf_ra}, {12'd0, v.exp_ra});
        chk($sformatf("v%0d decode rf_rb", idx), {12'd0, bus.rf_rb}, {12'd0, v.exp_rb});
        chk($sformatf("v%0d decode illegal", idx), {15'd0, bus.illegal}, 16'd0);
        chk($sformatf("v%0d decode rf_we", idx), {15'd0, bus.rf_we}, 16'd0);
        tick();
        chk($sformatf("v%0d alu_sel", idx), {13'd0, bus.alu_sel}, {13'd0, v.exp_sel});
        chk($sformatf("v%0d illegal", idx), {15'd0, bus.illegal}, {15'd0, v.kind == K_ILL});
        chk($sformatf("v%0d alu_en early", idx), {15'd0, bus.alu_en}, 16'd0);
        if (v.kind != K_ALU) begin
            chk($sformatf("v%0d ready +1", idx), {15'd0, bus.instr_ready}, 16'd1);
            chk($sformatf("v%0d retired", idx), {8'd0, bus.retired}, {8'd0, v.exp_retired});
        end else begin
            chk($sformatf("v%0d exec ready", idx), {15'd0, bus.instr_ready}, 16'd0);
            tick();
            chk($sformatf("v%0d alu_en", idx), {15'd0, bus.alu_en}, 16'd1);
            chk($sformatf("v%0d rf_we early", idx), {15'd0, bus.rf_we}, 16'd0);
            chk($sformatf("v%0d exec rf_ra", idx), {12'd0, bus.rf_ra}, {12'd0, v.exp_ra});
            chk($sformatf("v%0d exec alu_sel", idx), {13'd0, bus.alu_sel}, {13'd0, v.exp_sel});
            tick();
            chk($sformatf("v%0d alu_en drop", idx), {15'd0, bus.alu_en}, 16'd0);
            chk($sformatf("v%0d rf_we", idx), {15'd0, bus.rf_we}, 16'd1);
            chk($sformatf("v%0d rf_wa", idx), {12'd0, bus.rf_wa}, {12'd0, v.exp_wa});
            chk($sformatf("v%0d retired", idx), {8'd0, bus.retired}, {8'd0, v.exp_retired});
            chk($sformatf("v%0d ready +3", idx), {15'd0, bus.instr_ready}, 16'd1);
        end
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[9];
        int   n;

        //          instr     kind   sel     ra    rb    wa    retired
        vecs[0] = '{16'h3A45, K_ALU, 3'd3, 4'h4, 4'h5, 4'hA, 8'd1};
        vecs[1] = '{16'h8000, K_NOP, 3'd3, 4'h0, 4'h0, 4'hA, 8'd2};
        vecs[2] = '{16'hF000, K_ILL, 3'd3, 4'h0, 4'h0, 4'hA, 8'd2};
        vecs[3] = '{16'h0123, K_ALU, 3'd0, 4'h2, 4'h3, 4'h1, 8'd3};
        vecs[4] = '{16'h5BCD, K_ALU, 3'd5, 4'hC, 4'hD, 4'hB, 8'd4};
        vecs[5] = '{16'h9ABC, K_ILL, 3'd5, 4'hB, 4'hC, 4'hB, 8'd4};
        vecs[6] = '{16'h8765, K_NOP, 3'd5, 4'h6, 4'h5, 4'hB, 8'd5};
        vecs[7] = '{16'hE2F1, K_ILL, 3'd5, 4'hF, 4'h1, 4'hB, 8'd5};
        vecs[8] = '{16'h7FFF, K_ALU, 3'd7, 4'hF, 4'hF, 4'hF, 8'd6};

        checks = 0;
        errors = 0;

        // Reset values
        do_reset();
        chk("rst ready",   {15'd0, bus.instr_ready}, 16'd1);
        chk("rst alu_sel", {13'd0, bus.alu_sel}, 16'd0);
        chk("rst alu_en",  {15'd0, bus.alu_en}, 16'd0);
        chk("rst rf_we",   {15'd0, bus.rf_we}, 16'd0);
        chk("rst illegal", {15'd0, bus.illegal}, 16'd0);
        chk("rst rf_ra",   {12'd0, bus.rf_ra}, 16'd0);
        chk("rst rf_rb",   {12'd0, bus.rf_rb}, 16'd0);
        chk("rst rf_wa",   {12'd0, bus.rf_wa}, 16'd0);
        chk("rst retired", {8'd0, bus.retired}, 16'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end
        tick();
        chk("tail illegal", {15'd0, bus.illegal}, 16'd0);
        chk("tail rf_we",   {15'd0, bus.rf_we}, 16'd0);
        chk("tail alu_sel", {13'd0, bus.alu_sel}, 16'd7);

        // Back-to-back with valid held high: second accept exactly 4 edges later
        do_reset();
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h1123;
        tick();
        bus.instr = 16'h6456;
        n = 0;
        while (bus.rf_ra !== 4'h5 && n < 10) begin
            tick();
            n++;
            if (n == 1) chk("b2b sel0", {13'd0, bus.alu_sel}, 16'd1);
        end
        chk("b2b spacing", 16'(n), 16'd4);
        bus.instr_valid = 1'b0;
        tick();
        chk("b2b sel1", {13'd0, bus.alu_sel}, 16'd6);
        tick();
        tick();
        chk("b2b rf_we",   {15'd0, bus.rf_we}, 16'd1);
        chk("b2b rf_wa",   {12'd0, bus.rf_wa}, 16'd4);
        chk("b2b retired", {8'd0, bus.retired}, 16'd2);

        // Reset during EXEC aborts the instruction; valid during reset ignored
        do_reset();
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h7FFF;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        chk("abort exec sel", {13'd0, bus.alu_sel}, 16'd7);
        rst_n           = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = 16'h3A45;
        tick();
        chk("abort alu_en",  {15'd0, bus.alu_en}, 16'd0);
        chk("abort alu_sel", {13'd0, bus.alu_sel}, 16'd0);
        chk("abort ready",   {15'd0, bus.instr_ready}, 16'd1);
        rst_n           = 1'b1;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort rf_we",   {15'd0, bus.rf_we}, 16'd0);
            chk("abort retired", {8'd0, bus.retired}, 16'd0);
            chk("abort ready2",  {15'd0, bus.instr_ready}, 16'd1);
            chk("abort rf_ra",   {12'd0, bus.rf_ra}, 16'd0);
        end

        // Retired counter wraps after 256 ALU ops
        do_reset();
        for (int i = 0; i < 256; i++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = {1'b0, 3'((i * 3) % 8), 12'h123};
            tick();
            bus.instr_valid = 1'b0;
            tick();
            tick();
            tick();
            if (i == 254) chk("wrap 255", {8'd0, bus.retired}, 16'd255);
        end
        chk("wrap rf_we",   {15'd0, bus.rf_we}, 16'd1);
        chk("wrap retired", {8'd0, bus.retired}, 16'd0);
        tick();
        tick();
        chk("wrap held sel", {13'd0, bus.alu_sel}, 16'd5);
        chk("wrap ready",    {15'd0, bus.instr_ready}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
